// File: rtl/issue_decode_queue_if.sv
// Fetch-to-issue bundle for the issue decode queue: instruction push side,
// flush, reservation-station full flags and the registered issue outputs.
interface issue_decode_queue_if #(
  parameter int DEPTH  = 4,
  parameter int NUM_RS = 3,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] inst_in;
  logic              inst_valid;
  logic              inst_ready;
  logic              flush;
  logic [NUM_RS-1:0] isFull;
  logic              issue_valid;
  logic [INST_W-1:0] issue_inst;
  logic [1:0]        ALUop;
  logic [1:0]        ALUSel;
  logic [NUM_RS-1:0] ResStationEN;
  logic              RegDst;
  logic              vkSrc;
  logic              stall;
  logic [CNT_W-1:0]  count;

  modport master (
    output inst_in, inst_valid, flush, isFull,
    input  inst_ready, issue_valid, issue_inst, ALUop, ALUSel,
           ResStationEN, RegDst, vkSrc, stall, count
  );

  modport slave (
    input  inst_in, inst_valid, flush, isFull,
    output inst_ready, issue_valid, issue_inst, ALUop, ALUSel,
           ResStationEN, RegDst, vkSrc, stall, count
  );
endinterface

// File: rtl/issue_decode_queue.sv
// In-order instruction queue that decodes its head entry and issues at most
// one instruction per cycle into a non-full reservation-station class.
module issue_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int NUM_RS = 3,
  parameter int INST_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  issue_decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [5:0] OP_RFORMAT = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_MULU  = 6'b011001;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] SEL_ADDSUB = 2'd0;
  localparam logic [1:0] SEL_MUL    = 2'd1;
  localparam logic [1:0] SEL_DIV    = 2'd2;

  localparam logic FROM_RT     = 1'b0;
  localparam logic FROM_RD     = 1'b1;
  localparam logic FROM_IMMD   = 1'b0;
  localparam logic FROM_RTDATA = 1'b1;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              issue_valid_q, issue_valid_d;
  logic [INST_W-1:0] issue_inst_q, issue_inst_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [1:0]        alu_sel_q, alu_sel_d;
  logic [NUM_RS-1:0] rs_en_q, rs_en_d;
  logic              reg_dst_q, reg_dst_d;
  logic              vk_src_q, vk_src_d;

  logic [INST_W-1:0] head;
  logic [5:0]        head_op;
  logic [5:0]        head_func;
  logic              head_is_r;
  logic [1:0]        head_cls;
  logic [1:0]        head_alu_op;
  logic [NUM_RS-1:0] class_oh;
  logic              head_full;
  logic              not_empty;
  logic              ready;
  logic              push;
  logic              fire;

  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[31:26];
  assign head_func = head[5:0];
  assign head_is_r = (head_op == OP_RFORMAT);

  // Only R-format MULU/DIVU leave the add/sub class; I-format low bits are immediates.
  always_comb begin
    head_cls = SEL_ADDSUB;
    if (head_is_r && head_func == FUNC_MULU) head_cls = SEL_MUL;
    if (head_is_r && head_func == FUNC_DIVU) head_cls = SEL_DIV;
  end

  always_comb begin
    head_alu_op = ALU_ADD;
    if (head_is_r) begin
      case (head_func)
        FUNC_ADD, FUNC_MULU: head_alu_op = ALU_ADD;
        FUNC_SUB:            head_alu_op = ALU_SUB;
        FUNC_AND:            head_alu_op = ALU_AND;
        default:             head_alu_op = ALU_OR;
      endcase
    end else if (head_op == OP_ORI) begin
      head_alu_op = ALU_OR;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : g_class_oh
      assign class_oh[gi] = (head_cls == 2'(gi));
    end
  endgenerate

  assign not_empty = (count_q != '0);
  assign ready     = (count_q != CNT_W'(DEPTH));
  assign head_full = |(bus.isFull & class_oh);
  assign fire      = not_empty && !head_full && !bus.flush;
  // Push is judged on the pre-pop occupancy: a full queue never accepts.
  assign push      = bus.inst_valid && ready && !bus.flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    issue_valid_d = 1'b0;
    rs_en_d       = '0;
    issue_inst_d  = issue_inst_q;
    alu_op_d      = alu_op_q;
    alu_sel_d     = alu_sel_q;
    reg_dst_d     = reg_dst_q;
    vk_src_d      = vk_src_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fire) begin
        rd_ptr_d      = rd_ptr_q + 1'b1;
        issue_valid_d = 1'b1;
        rs_en_d       = class_oh;
        issue_inst_d  = head;
        alu_op_d      = head_alu_op;
        alu_sel_d     = head_cls;
        reg_dst_d     = head_is_r ? FROM_RD : FROM_RT;
        vk_src_d      = head_is_r ? FROM_RTDATA : FROM_IMMD;
      end
      if (push && !fire)      count_d = count_q + CNT_W'(1);
      else if (fire && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      alu_op_q      <= ALU_ADD;
      alu_sel_q     <= SEL_ADDSUB;
      rs_en_q       <= '0;
      reg_dst_q     <= FROM_RT;
      vk_src_q      <= FROM_IMMD;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      alu_op_q      <= alu_op_d;
      alu_sel_q     <= alu_sel_d;
      rs_en_q       <= rs_en_d;
      reg_dst_q     <= reg_dst_d;
      vk_src_q      <= vk_src_d;
    end
  end

  // Storage carries no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.inst_in;
  end

  assign bus.inst_ready   = ready;
  assign bus.stall        = not_empty && head_full;
  assign bus.count        = count_q;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_inst   = issue_inst_q;
  assign bus.ALUop        = alu_op_q;
  assign bus.ALUSel       = alu_sel_q;
  assign bus.ResStationEN = rs_en_q;
  assign bus.RegDst       = reg_dst_q;
  assign bus.vkSrc        = vk_src_q;
endmodule

// File: tb/tb_issue_decode_queue.sv
// Bench for issue_decode_queue: directed stimulus, a queue-based reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_issue_decode_queue;
  localparam int DEPTH = 4;
  localparam int NUM_RS = 3;
  localparam int INST_W = 32;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_MULU = 6'b011001, F_DIVU = 6'b011011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  issue_decode_queue_if #(.DEPTH(DEPTH), .NUM_RS(NUM_RS), .INST_W(INST_W)) bus ();

  issue_decode_queue #(.DEPTH(DEPTH), .NUM_RS(NUM_RS), .INST_W(INST_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rinst(input logic [5:0] f, input logic [19:0] tag);
    return {OP_R, tag, f};
  endfunction

  function automatic logic [31:0] iinst(input logic [5:0] op, input logic [25:0] imm);
    return {op, imm};
  endfunction

  // Spec rules: reservation-station class and ALU operation of an instruction.
  function automatic int cls_of(input logic [31:0] i);
    if (i[31:26] != OP_R) return 0;
    if (i[5:0] == F_MULU) return 1;
    if (i[5:0] == F_DIVU) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] aluop_of(input logic [31:0] i);
    if (i[31:26] == OP_ORI) return 2'd3;
    if (i[31:26] != OP_R) return 2'd0;
    if (i[5:0] == F_ADD || i[5:0] == F_MULU) return 2'd0;
    if (i[5:0] == F_SUB) return 2'd1;
    if (i[5:0] == F_AND) return 2'd2;
    return 2'd3;
  endfunction

  // Reference model: a plain queue of waiting instructions plus expected outputs.
  logic [31:0] mq[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_inst = '0;
  logic [1:0]  exp_aluop = 2'd0;
  logic [1:0]  exp_sel = 2'd0;
  logic [2:0]  exp_en = 3'b000;
  logic        exp_regdst = 1'b0;
  logic        exp_vksrc = 1'b0;
  logic        m_fire, m_push;
  logic [31:0] m_head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_valid = 1'b0; exp_inst = '0; exp_aluop = 2'd0; exp_sel = 2'd0;
      exp_en = 3'b000; exp_regdst = 1'b0; exp_vksrc = 1'b0;
    end else begin
      m_fire = (mq.size() != 0) && !bus.flush && !bus.isFull[cls_of(mq[0])];
      m_push = bus.inst_valid && (mq.size() < DEPTH) && !bus.flush;
      exp_valid = 1'b0;
      exp_en = 3'b000;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (m_fire) begin
          m_head = mq.pop_front();
          exp_valid = 1'b1;
          exp_inst = m_head;
          exp_sel = 2'(cls_of(m_head));
          exp_en = 3'(1 << cls_of(m_head));
          exp_aluop = aluop_of(m_head);
          exp_regdst = (m_head[31:26] == OP_R);
          exp_vksrc = (m_head[31:26] == OP_R);
        end
        if (m_push) mq.push_back(bus.inst_in);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_issue_valid", 32'(bus.issue_valid), 32'(exp_valid));
      chk("m_issue_inst", bus.issue_inst, exp_inst);
      chk("m_ALUop", 32'(bus.ALUop), 32'(exp_aluop));
      chk("m_ALUSel", 32'(bus.ALUSel), 32'(exp_sel));
      chk("m_ResStationEN", 32'(bus.ResStationEN), 32'(exp_en));
      chk("m_RegDst", 32'(bus.RegDst), 32'(exp_regdst));
      chk("m_vkSrc", 32'(bus.vkSrc), 32'(exp_vksrc));
      chk("m_count", 32'(bus.count), 32'(mq.size()));
      chk("m_inst_ready", 32'(bus.inst_ready), 32'(mq.size() < DEPTH));
      chk("m_stall", 32'(bus.stall),
          32'((mq.size() != 0) && bus.isFull[cls_of(mq.size() != 0 ? mq[0] : 32'h0)]));
      if (bus.issue_valid)
        $display("issue inst=%08h ALUop=%0d ALUSel=%0d EN=%b count=%0d",
                 bus.issue_inst, bus.ALUop, bus.ALUSel, bus.ResStationEN, bus.count);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_valid"}, 32'(bus.issue_valid), 0);
    chk({tag, "_inst"}, bus.issue_inst, 0);
    chk({tag, "_ALUop"}, 32'(bus.ALUop), 0);
    chk({tag, "_ALUSel"}, 32'(bus.ALUSel), 0);
    chk({tag, "_EN"}, 32'(bus.ResStationEN), 0);
    chk({tag, "_RegDst"}, 32'(bus.RegDst), 0);
    chk({tag, "_vkSrc"}, 32'(bus.vkSrc), 0);
    chk({tag, "_ready"}, 32'(bus.inst_ready), 1);
  endtask

  logic [31:0] list[5];
  logic [31:0] prev;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_in = '0; bus.inst_valid = 1'b0; bus.flush = 1'b0; bus.isFull = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    cyc();

    // Single ADD, no back-pressure: issues one cycle after the push.
    bus.inst_in = rinst(F_ADD, 20'h00011); bus.inst_valid = 1'b1;
    cyc();
    bus.inst_valid = 1'b0;
    chk("add_count", 32'(bus.count), 1);
    chk("add_not_yet", 32'(bus.issue_valid), 0);
    cyc();
    chk("add_valid", 32'(bus.issue_valid), 1);
    chk("add_ALUop", 32'(bus.ALUop), 0);
    chk("add_ALUSel", 32'(bus.ALUSel), 0);
    chk("add_EN", 32'(bus.ResStationEN), 3'b001);
    chk("add_RegDst", 32'(bus.RegDst), 1);
    chk("add_vkSrc", 32'(bus.vkSrc), 1);
    cyc();
    chk("add_after_valid", 32'(bus.issue_valid), 0);
    chk("add_after_EN", 32'(bus.ResStationEN), 0);

    // MULU blocked by multiply class full; ADDI (MULU-like low bits) must wait behind it.
    bus.isFull = 3'b010;
    bus.inst_in = rinst(F_MULU, 20'h00022); bus.inst_valid = 1'b1;
    cyc();
    bus.inst_in = iinst(OP_ADDI, 26'h0000019);
    cyc();
    bus.inst_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("blk_stall", 32'(bus.stall), 1);
      chk("blk_count", 32'(bus.count), 2);
      chk("blk_valid", 32'(bus.issue_valid), 0);
      cyc();
    end
    bus.isFull = 3'b000;
    cyc();
    chk("mulu_EN", 32'(bus.ResStationEN), 3'b010);
    chk("mulu_ALUSel", 32'(bus.ALUSel), 1);
    chk("mulu_inst", bus.issue_inst, rinst(F_MULU, 20'h00022));
    cyc();
    chk("addi_EN", 32'(bus.ResStationEN), 3'b001);
    chk("addi_ALUop", 32'(bus.ALUop), 0);
    chk("addi_RegDst", 32'(bus.RegDst), 0);
    chk("addi_vkSrc", 32'(bus.vkSrc), 0);
    cyc();

    // Fill to DEPTH with all classes full; fifth push held off.
    list[0] = rinst(F_SUB, 20'h00031);
    list[1] = rinst(F_AND, 20'h00032);
    list[2] = rinst(F_DIVU, 20'h00033);
    list[3] = iinst(OP_ORI, 26'h000001B);
    list[4] = rinst(F_OR, 20'h00035);
    bus.isFull = 3'b111;
    for (int i = 0; i < 5; i++) begin
      bus.inst_in = list[i]; bus.inst_valid = 1'b1;
      cyc();
      if (i == 3) chk("full_ready", 32'(bus.inst_ready), 0);
    end
    bus.inst_valid = 1'b0;
    chk("full_count", 32'(bus.count), 4);
    bus.isFull = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_valid", 32'(bus.issue_valid), 1);
      chk("drain_inst", bus.issue_inst, list[i]);
    end
    chk("drain_count", 32'(bus.count), 0);
    cyc();
    chk("drain_no5th", 32'(bus.issue_valid), 0);

    // Streaming: one push and one issue per cycle, occupancy stays at 1.
    for (int i = 0; i < 8; i++) begin
      bus.inst_in = (i % 2 == 0) ? rinst(F_ADD, 20'(32'h100 + i)) : iinst(OP_ORI, 26'(32'h200 + i));
      bus.inst_valid = 1'b1;
      cyc();
      chk("stream_count", 32'(bus.count), 1);
      if (i > 0) begin
        chk("stream_valid", 32'(bus.issue_valid), 1);
        chk("stream_inst", bus.issue_inst, prev);
      end
      prev = bus.inst_in;
    end
    bus.inst_valid = 1'b0;
    cyc();
    chk("stream_last", bus.issue_inst, prev);
    chk("stream_empty", 32'(bus.count), 0);
    cyc();

    // Flush with a simultaneous push at count=3.
    bus.isFull = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.inst_in = rinst(F_ADD, 20'(32'h300 + i)); bus.inst_valid = 1'b1;
      cyc();
    end
    chk("flush_pre_count", 32'(bus.count), 3);
    bus.flush = 1'b1; bus.inst_in = rinst(F_SUB, 20'h00BAD);
    #1;
    chk("flush_ready", 32'(bus.inst_ready), 1);
    cyc();
    bus.flush = 1'b0; bus.inst_valid = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_valid", 32'(bus.issue_valid), 0);
    bus.isFull = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_none", 32'(bus.issue_valid), 0);
    end

    // Asynchronous reset between edges while an issue is visible.
    bus.inst_in = rinst(F_MULU, 20'h00401); bus.inst_valid = 1'b1;
    cyc();
    bus.inst_in = rinst(F_AND, 20'h00402);
    cyc();
    bus.inst_valid = 1'b0;
    chk("pre_arst_valid", 32'(bus.issue_valid), 1);
    chk("pre_arst_count", 32'(bus.count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_arst_count", 32'(bus.count), 0);
    chk("post_arst_valid", 32'(bus.issue_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/issue_decode_queue.md
Name: issue_decode_queue

Overview:
- Parametrised successor to the single-instruction issue decoder of the Tomasulo core.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes the head entry into ALU opcode, functional-unit select, reservation-station enable, RegDst and vkSrc.
- Issues at most one instruction per cycle, only when the target reservation-station class is not full. Registered issue outputs feed the reservation stations and register-status table.

Parameters:
- DEPTH, 4, number of instruction-queue entries; power of two, at least 2.
- NUM_RS, 3, number of reservation-station classes (0 addsub, 1 multiply, 2 divide); width of isFull and ResStationEN.
- INST_W, 32, instruction word width; op is bits [31:26], func is bits [5:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst_in  in  INST_W  instruction from fetch
- inst_valid  in  1  inst_in is valid this cycle
- inst_ready  out  1  queue can accept; equals (count < DEPTH)
- flush  in  1  synchronous clear of queue and issue register
- isFull  in  NUM_RS  per-class reservation-station full flags
- issue_valid  out  1  registered; one-cycle pulse per issued instruction
- issue_inst  out  INST_W  registered copy of the issued instruction
- ALUop  out  2  registered; `ALUAdd/`ALUSub/`ALUAnd/`ALUOr
- ALUSel  out  2  registered; `addsubALU/`multipleALU/`divideALU
- ResStationEN  out  NUM_RS  registered one-hot; all zero when issue_valid=0
- RegDst  out  1  registered; `FromRd if op==`opRFormat, else `FromRt
- vkSrc  out  1  registered; `FromRtData if op==`opRFormat, else `FromImmd
- stall  out  1  combinational; queue non-empty and head class full
- count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): queue empty, count=0, rd/wr pointers=0, issue_valid=0, issue_inst=0, ALUop=`ALUAdd, ALUSel=`addsubALU, ResStationEN=0, RegDst=`FromRt, vkSrc=`FromImmd. Reset asserted mid-operation discards all entries immediately.
- Push: when inst_valid && inst_ready, write inst_in at wr_ptr, then wr_ptr+1 (mod DEPTH).
- No bypass: a full queue does not accept a push even when an issue happens in the same cycle.
- Class decode of the head entry:
  - func==`funcMULU under `opRFormat -> class 1
  - func==`funcDIVU under `opRFormat -> class 2
  - everything else -> class 0
  - Non-R-format instructions never select mul/div, whatever their low bits are.
- ALUop decode:
  - R-format: ADD/MULU -> `ALUAdd; SUB -> `ALUSub; AND -> `ALUAnd; other func -> `ALUOr.
  - `opADDI -> `ALUAdd; `opORI -> `ALUOr; any other op -> `ALUAdd.
- Issue fire = count!=0 && !isFull[class] && !flush.
  - On fire: pop the head, rd_ptr+1 (mod DEPTH).
  - Next edge: issue_valid=1, with decoded fields and issue_inst registered.
  - Latency: an instruction pushed at edge N can issue at the earliest at edge N+1, with outputs visible after edge N+1.
- No fire: issue_valid=0 and ResStationEN=0. Other registered fields hold their last value.
- Simultaneous push and fire: count unchanged, both pointers advance.
- Empty queue: no fire, stall=0.
- isFull of the head class held high: head waits, stall=1, and the queue continues accepting pushes until full. Younger instructions are never reordered ahead of the head (in-order issue).
- flush: next edge gives count=0, pointers=0, issue_valid=0, ResStationEN=0.
  - Flush beats a simultaneous push, which is dropped, and a simultaneous fire.
  - inst_ready may read 1 during flush; a push that cycle is still dropped.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.

Test Plan:
- Reset, push ADD R-format, isFull=000 -> one cycle later issue_valid=1, ALUop=`ALUAdd, ALUSel=`addsubALU, ResStationEN=001, RegDst=`FromRd, vkSrc=`FromRtData; next cycle issue_valid=0, ResStationEN=000.
- Push MULU then ADDI with isFull=010 held 3 cycles -> stall=1, count=2, no issue and ADDI not bypassed; release isFull -> MULU issues (ResStationEN=010), then ADDI (ALUop=`ALUAdd, RegDst=`FromRt, vkSrc=`FromImmd, EN=001).
- DEPTH=4, isFull=111, push 5 instructions -> inst_ready=0 after the 4th, 5th held off, count=4; release -> 4 issues on consecutive cycles, pointers wrap, count back to 0.
- Continuous push of 8 instructions with isFull=000 -> one issue per cycle in program order, count stable at 1 and never above 1.
- count=3 with flush and inst_valid asserted together -> next cycle count=0, issue_valid=0, pushed instruction never issued.
- Drop rst_n asynchronously mid-stream between clock edges -> all outputs take reset values immediately, before the next clock edge.
